line_delay_chain: RTL and testbench
===================================

LINE_DELAY_CHAIN -- requirements
Module: line_delay_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel data width.
REQ-002 SHALL have parameter STAT_W, default 3, status width (VS/HS/DE-type flags).
REQ-003 SHALL have parameter HS_BIT, default 1, index of HS within stat_in.
REQ-004 SHALL have parameter TAPS, default 4, number of line delays (1..8).
REQ-005 SHALL have parameter ADDR_W, default 11, so maximum line length is 2^ADDR_W pixels.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, pixel enable; 0 freezes all state.
REQ-009 SHALL have port data_in, input, DATA_W, current pixel.
REQ-010 SHALL have port stat_in, input, STAT_W, current status.
REQ-011 SHALL have port taps_o, output, (TAPS+1)*DATA_W, slice k = pixel delayed k lines; slice 0 = data_in.
REQ-012 SHALL have port stat_o, output, STAT_W, status aligned with slice TAPS.
REQ-013 SHALL have port tap_valid, output, TAPS+1, bit k = slice k holds real data.
REQ-014 SHALL have port line_len, output, ADDR_W+1, currently used line length L.
REQ-015 SHALL have port len_err, output, 1, sticky overlong/zero-line flag.

Function
REQ-016 SHALL detect HS on rising edge of stat_in[HS_BIT] sampled on enabled cycles only.
REQ-017 SHALL count enabled cycles between consecutive HS rising edges, the edge cycle counted as pixel 0 of the new line.
REQ-018 SHALL, at each HS edge, load the measured count into line_len if 2 <= count <= 2^ADDR_W; otherwise keep line_len and set len_err.
REQ-019 SHALL saturate the measuring counter at 2^ADDR_W+1 (no wrap).
REQ-020 SHALL delay each tap by exactly line_len enabled cycles, data and status stored together (DATA_W+STAT_W bits per entry).
REQ-021 SHALL use one shared ring address, incrementing per enabled cycle and wrapping to 0 after line_len-2 (ring period L-1 plus one output register stage).
REQ-022 SHALL, when line_len changes, reset the ring address to 0 at the same cycle and clear tap_valid[TAPS:1].
REQ-023 SHALL hold tap_valid[0]=1 out of reset; set tap_valid[k] after k complete lines with stable line_len.
REQ-024 SHALL drive slice k and stat_o (for k=TAPS) to zero while tap_valid[k]=0.
REQ-025 SHALL, with en=0, hold address, counters, outputs and memory (no writes).
REQ-026 SHALL have no combinational path from inputs to outputs except slice 0 = data_in.

Reset
REQ-027 SHALL on rst clear address, measuring counter, line_len (0), len_err, tap_valid[TAPS:1], and pipeline registers; memory contents not cleared.
REQ-028 SHALL treat the first HS edge after reset as measurement start only; taps remain invalid until line_len is loaded.
REQ-029 SHALL let rst override en and any simultaneous HS edge.

Structure
REQ-030 SHALL place DATA_W/STAT_W defaults, HS bit index and entry-width helper in shared package video_pkg.
REQ-031 SHALL instantiate TAPS copies of one sub-module sp_ram_p (parametrised width/depth, single-port, read-first, registered output).
REQ-032 SHALL generate tap chain with a generate loop; slice k+1 memory input = slice k memory output.

Verification
REQ-033 SHALL verify: L=8 lines, ramp data, TAPS=4 -> slice k equals data_in from 8k cycles earlier, tap_valid=11111 after 4 lines.
REQ-034 SHALL verify: line length changes 8 -> 12 -> line_len=12 at next edge, tap_valid[4:1] cleared then refilled after 4 lines of 12.
REQ-035 SHALL verify: HS gap of 3000 with ADDR_W=11 -> len_err=1, line_len unchanged, counter saturated.
REQ-036 SHALL verify: en toggling 50% random with L=16 -> delays counted in enabled cycles only, outputs held when en=0.
REQ-037 SHALL verify: rst asserted mid-line with HS edge same cycle -> all outputs zero, tap_valid=00001, line_len=0 next cycle.
REQ-038 SHALL verify: stat_o equals stat_in delayed 4*L cycles including HS pulses.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video stream defaults and helpers
//
// Purpose: default pixel/status widths, HS flag position and the width of
// one line-memory entry (pixel plus status stored side by side).
// Ports: none (package).
package video_pkg;

  localparam int VID_DATA_W = 24;
  localparam int VID_STAT_W = 3;
  localparam int VID_HS_BIT = 1;

  // One memory word carries the pixel and its status flags together.
  function automatic int entry_w(input int data_w, input int stat_w);
    return data_w + stat_w;
  endfunction

endpackage

// File: rtl/sp_ram_p.sv
// rtl/sp_ram_p.sv - single-port read-first RAM with registered output
//
// Purpose: one line of storage for the delay chain. Each enabled cycle the
// word at addr is read into rdata and then overwritten with wdata.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears rdata only)
//   en        : access enable; 0 freezes memory and rdata
//   addr      : word address
//   wdata     : word written at addr
//   rdata     : previous content of addr, one cycle later
module sp_ram_p #(
  parameter int WIDTH  = 27,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Memory array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/line_delay_chain.sv
// rtl/line_delay_chain.sv - multi-tap video line delay with auto line length
//
// Purpose: measures the line length from HS rising edges and provides the
// current pixel plus TAPS copies delayed by 1..TAPS lines.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : pixel enable; 0 freezes all state
//   data_in   : current pixel
//   stat_in   : current status flags (HS at HS_BIT)
//   taps_o    : slice k = pixel delayed k lines, slice 0 = data_in
//   stat_o    : status aligned with slice TAPS
//   tap_valid : bit k set when slice k holds real data
//   line_len  : line length L in use (0 until first measurement)
//   len_err   : sticky flag for a rejected (too long/short) line
module line_delay_chain
  import video_pkg::*;
#(
  parameter int DATA_W = VID_DATA_W,
  parameter int STAT_W = VID_STAT_W,
  parameter int HS_BIT = VID_HS_BIT,
  parameter int TAPS   = 4,
  parameter int ADDR_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [STAT_W-1:0]         stat_in,
  output logic [(TAPS+1)*DATA_W-1:0] taps_o,
  output logic [STAT_W-1:0]         stat_o,
  output logic [TAPS:0]             tap_valid,
  output logic [ADDR_W:0]           line_len,
  output logic                      len_err
);

  localparam int ENTRY_W = entry_w(DATA_W, STAT_W);
  localparam int CW      = ADDR_W + 1;
  localparam int LD_W    = $clog2(TAPS + 1);
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0] CNT_SAT = CNT_MAX + CW'(1);

  logic              hs_prev;
  logic              hs_edge;
  logic              armed;
  logic [CW-1:0]     meas_cnt;
  logic              len_ok;
  logic              len_load;
  logic [CW-1:0]     len_use;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_use;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CW-1:0]     pix_cnt;
  logic [LD_W-1:0]   lines_done;

  logic [ENTRY_W-1:0] chain [TAPS+1];

  always_comb begin
    hs_edge  = en & stat_in[HS_BIT] & ~hs_prev;
    len_ok   = (meas_cnt >= CW'(2)) && (meas_cnt <= CNT_MAX);
    // Only a real change of length restarts the ring and the fill tracking.
    len_load = hs_edge && armed && len_ok && (meas_cnt != line_len);
    len_use  = len_load ? meas_cnt : line_len;
    // The edge pixel of a new length is written at address 0 so that it is
    // the first entry read back exactly one line later.
    addr_use = len_load ? '0 : addr_q;
    addr_nxt = '0;
    if (len_use >= CW'(2) && ({1'b0, addr_use} != len_use - CW'(2))) begin
      addr_nxt = addr_use + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev    <= 1'b0;
      armed      <= 1'b0;
      meas_cnt   <= '0;
      line_len   <= '0;
      len_err    <= 1'b0;
      addr_q     <= '0;
      pix_cnt    <= '0;
      lines_done <= '0;
    end else if (en) begin
      hs_prev <= stat_in[HS_BIT];
      addr_q  <= addr_nxt;

      // The edge cycle is pixel 0 of the new line, so the next one is 1.
      if (hs_edge) begin
        meas_cnt <= CW'(1);
        armed    <= 1'b1;
        if (armed && !len_ok) begin
          len_err <= 1'b1;
        end
        if (len_load) begin
          line_len <= meas_cnt;
        end
      end else if (meas_cnt != CNT_SAT) begin
        meas_cnt <= meas_cnt + CW'(1);
      end

      // Count complete lines since the length last changed.
      if (len_load) begin
        pix_cnt    <= CW'(1);
        lines_done <= '0;
      end else if (line_len != '0) begin
        if (pix_cnt == line_len - CW'(1)) begin
          pix_cnt <= '0;
          if (lines_done != LD_W'(TAPS)) begin
            lines_done <= lines_done + LD_W'(1);
          end
        end else begin
          pix_cnt <= pix_cnt + CW'(1);
        end
      end
    end
  end

  assign chain[0]     = {stat_in, data_in};
  assign tap_valid[0] = 1'b1;
  assign taps_o[DATA_W-1:0] = data_in;

  // Ring period is L-1; the RAM output register supplies the last cycle.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    sp_ram_p #(
      .WIDTH  (ENTRY_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .addr  (addr_use),
      .wdata (chain[k]),
      .rdata (chain[k+1])
    );

    assign tap_valid[k+1] = (int'(lines_done) >= k + 1);
    assign taps_o[(k+1)*DATA_W +: DATA_W] =
      tap_valid[k+1] ? chain[k+1][DATA_W-1:0] : '0;
  end

  assign stat_o = tap_valid[TAPS] ? chain[TAPS][ENTRY_W-1 -: STAT_W] : '0;

endmodule

// File: tb/tb_line_delay_chain.sv
// tb/tb_line_delay_chain.sv - scoreboard bench for line_delay_chain
module tb_line_delay_chain;

  localparam int DW = 24;
  localparam int SW = 3;
  localparam int NT = 4;
  localparam int AW = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [DW-1:0]         data_in;
  logic [SW-1:0]         stat_in;
  logic [(NT+1)*DW-1:0]  taps_o;
  logic [SW-1:0]         stat_o;
  logic [NT:0]           tap_valid;
  logic [AW:0]           line_len;
  logic                  len_err;

  line_delay_chain #(
    .DATA_W (DW),
    .STAT_W (SW),
    .HS_BIT (1),
    .TAPS   (NT),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .stat_in   (stat_in),
    .taps_o    (taps_o),
    .stat_o    (stat_o),
    .tap_valid (tap_valid),
    .line_len  (line_len),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [(NT+1)*DW-1:0] taps;
    logic [SW-1:0]        st;
    logic [NT:0]          tv;
    logic [AW:0]          ll;
    logic                 err;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state, indexed by enabled-cycle number since start.
  logic [DW-1:0] hist_d [0:8191];
  logic [SW-1:0] hist_s [0:8191];
  int  m_e = 0, m_len = 0, m_chg = 0, m_last = 0;
  bit  m_armed = 0, m_err = 0, m_hs = 0, m_known = 0;
  int  ramp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_t x;
    int   cnt;
    @(posedge clk);
    #1;
    rst = r; en = e; data_in = d; stat_in = s;
    if (m_known) begin
      x = '0;
      x.taps[DW-1:0] = d;
      x.tv[0] = 1'b1;
      for (int k = 1; k <= NT; k++) begin
        if (m_len != 0 && (m_e - k * m_len) >= m_chg) begin
          x.tv[k] = 1'b1;
          x.taps[k*DW +: DW] = hist_d[m_e - k * m_len];
        end
      end
      if (x.tv[NT]) x.st = hist_s[m_e - NT * m_len];
      x.ll  = (AW+1)'(m_len);
      x.err = m_err;
      exp_q.push_back(x);
    end
    if (r) begin
      m_len = 0; m_err = 0; m_armed = 0; m_hs = 0; m_known = 1;
    end else if (e) begin
      hist_d[m_e] = d;
      hist_s[m_e] = s;
      if (s[1] && !m_hs) begin
        if (m_armed) begin
          cnt = m_e - m_last;
          if (cnt >= 2 && cnt <= (1 << AW)) begin
            if (cnt != m_len) begin
              m_len = cnt;
              m_chg = m_e;
            end
          end else begin
            m_err = 1;
          end
        end
        m_last  = m_e;
        m_armed = 1;
      end
      m_hs = s[1];
      m_e++;
    end
  endtask

  function automatic logic [SW-1:0] stat_of(input int p);
    logic [31:0] rv;
    rv = 32'(ramp);
    return {rv[4], p < 2, p >= 2};
  endfunction

  // Lines with a 2-pixel HS pulse at pixel 0 and ramp data; with rnd_en,
  // disabled cycles carrying random data/status are interleaved.
  task automatic line(input int len, input int n, input bit rnd_en);
    int gap;
    for (int l = 0; l < n; l++) begin
      for (int p = 0; p < len; p++) begin
        gap = 0;
        while (rnd_en && $urandom_range(0, 1) == 0 && gap < 4) begin
          cycle(1'b0, 1'b0, DW'($urandom), SW'($urandom));
          gap++;
        end
        cycle(1'b0, 1'b1, DW'(ramp), stat_of(p));
        ramp++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    exp_t got;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      got = '{taps: taps_o, st: stat_o, tv: tap_valid, ll: line_len, err: len_err};
      checks++;
      if (got !== x) begin
        failures++;
        $display("FAIL cyc_out t=%0t act=%h exp=%h", $time, got, x);
      end
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data_in = '0; stat_in = '0;
    cycle(1'b1, 1'b1, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0);
    settle();
    chk("rst_valid", 64'(tap_valid), 64'd1);
    chk("rst_len", 64'(line_len), 64'd0);
    chk("rst_err", 64'(len_err), 64'd0);
    chk("rst_taps_zero", 64'(|taps_o[(NT+1)*DW-1:DW]), 64'd0);

    // L=8 ramp: slice k lags by 8k pixels, all taps valid after 4 lines.
    line(8, 6, 1'b0);
    settle();
    chk("l8_valid", 64'(tap_valid), 64'h1f);
    chk("l8_len", 64'(line_len), 64'd8);
    chk("l8_tap1", 64'(taps_o[DW +: DW]), 64'(ramp - 1 - 8));
    chk("l8_tap4", 64'(taps_o[4*DW +: DW]), 64'(ramp - 1 - 32));

    // 8 -> 12: first 12-line still measures 8; the next edge loads 12.
    line(12, 1, 1'b0);
    settle();
    chk("l12a_len", 64'(line_len), 64'd8);
    line(12, 1, 1'b0);
    settle();
    chk("l12b_len", 64'(line_len), 64'd12);
    chk("l12b_valid", 64'(tap_valid), 64'h01);
    line(12, 1, 1'b0);
    settle();
    chk("l12c_valid", 64'(tap_valid), 64'h03);
    line(12, 3, 1'b0);
    settle();
    chk("l12d_valid", 64'(tap_valid), 64'h1f);

    // 3000-pixel gap: counter saturates, line rejected, length kept.
    line(3000, 1, 1'b0);
    settle();
    chk("sat_cnt", 64'(dut.meas_cnt), 64'd2049);
    chk("sat_err_pre", 64'(len_err), 64'd0);
    line(12, 1, 1'b0);
    settle();
    chk("long_err", 64'(len_err), 64'd1);
    chk("long_len", 64'(line_len), 64'd12);

    // L=16 with random enable gaps.
    line(16, 6, 1'b1);
    settle();
    chk("l16_len", 64'(line_len), 64'd16);
    chk("l16_valid", 64'(tap_valid), 64'h1f);

    // Reset mid-line together with an HS rising edge.
    for (int p = 0; p < 7; p++) begin
      cycle(1'b0, 1'b1, DW'(ramp), stat_of(p));
      ramp++;
    end
    cycle(1'b1, 1'b1, DW'(ramp), 3'b010);
    cycle(1'b0, 1'b0, '0, '0);
    settle();
    chk("mrst_valid", 64'(tap_valid), 64'd1);
    chk("mrst_len", 64'(line_len), 64'd0);
    chk("mrst_err", 64'(len_err), 64'd0);
    chk("mrst_taps_zero", 64'(|taps_o[(NT+1)*DW-1:DW]), 64'd0);
    chk("mrst_stat", 64'(stat_o), 64'd0);

    // First edge after reset only starts measuring.
    line(8, 1, 1'b0);
    settle();
    chk("rearm_len", 64'(line_len), 64'd0);
    line(8, 5, 1'b0);
    settle();
    chk("relock_len", 64'(line_len), 64'd8);
    chk("relock_valid", 64'(tap_valid), 64'h1f);

    cycle(1'b0, 1'b0, '0, '0);
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
